car_sequencer: RTL and testbench
================================

Name: car_sequencer

Overview:
- Microsequencer for the MSP430 CPU.
- Owns the Control Address Register (CAR) that drives the control unit. Each cycle the control unit turns CAR into a control word, datapath selects and IW alterations.
- Decodes the fetched word at CAR_0 into an entry state, then walks the multi-cycle operand/execute chain.
- Stalls on memory wait and inserts the interrupt-entry chain at instruction boundaries.

Parameters:
- CAR_BITS, 6, width of CAR; must cover all 60 CAR_* encodings.

Ports:
- MCLK  in  1  system clock; all state updates on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- FETCH_WORD  in  16  instruction word on the memory bus during CAR_0; IR captures it on the same edge.
- MEM_WAIT  in  1  memory not ready; holds CAR.
- INTREQ  in  1  maskable interrupt pending.
- GIE  in  1  SR.GIE, current value.
- NMI  in  1  non-maskable interrupt pending.
- CAR  out  CAR_BITS  control address to the control unit.
- IN_INT  out  1  high while CAR is CAR_INT0..CAR_INT4.
- INSTR_END  out  1  high in the last state of an instruction: the state whose successor is CAR_0 or CAR_INT0.

Behaviour:
- Reset:
  - RSTn low forces CAR=CAR_0 immediately, asynchronously, from any state, including mid-chain.
  - While reset is asserted: IN_INT=0, INSTR_END=0.
  - First fetch occurs on the first MCLK edge after RSTn rises.
- Stall: MEM_WAIT=1 holds CAR in every state, including CAR_0 with no decode. Interrupt sampling is also deferred while stalled.
- Timing:
  - One state per cycle; CAR registered.
  - Outputs IN_INT and INSTR_END are combinational from CAR.
- Decode at CAR_0 (takes FETCH_WORD; src=[11:8], As=[5:4], Ad=[7], reg1=[3:0]):
  - Source mode S:
    - As=00 → REG.
    - As=01 → IDX, except reg R3 → REG.
    - As=10/11 → IND, except reg R2 or R3 → REG (constant generator).
  - Format 2 uses reg1 as the source register for this mapping.
  - Jump, [15:13]=001 → CAR_JMP0.
  - Format 1, [15:12]>=4: entry by S and Ad:
    - REG/0 → REG_REG.
    - REG/1 → REG_IDX0.
    - IND/0 → IND_REG0.
    - IND/1 → IND_IDX0.
    - IDX/0 → IDX_REG0.
    - IDX/1 → IDX_IDX0.
  - Format 2, [15:10]=000100, op=[9:7]:
    - op 000–011 → 1OP_{REG,IND0,IDX0}.
    - op 100 → PUSH_{REG0,IND0,IDX0}.
    - op 101 → CALL_{REG0,IND0,IDX0}.
    - op 110 → RETI0; As ignored.
    - op 111 → CAR_0 (no-op).
  - Any other word, including [15:12]=0 outside format 2 → CAR_0. No trap.
- Chains: each numbered state advances to index+1 until the last index.
  - Last indices: REG_IDX3, IND_REG1, IND_IDX4, IDX_REG2, IDX_IDX5, 1OP_IND2, 1OP_IDX3, PUSH_*{2,2,3}, CALL_*{2,2,3}, RETI3, JMP0.
  - Single-state chains: REG_REG, 1OP_REG.
- Instruction boundary: when in a last state and not stalled, next = CAR_INT0 if (NMI | (INTREQ & GIE)), else CAR_0.
  - RETI3 samples the GIE presented that cycle, i.e. the restored SR.
- Interrupt chain:
  - CAR_INT0..CAR_INT4 advance unconditionally (subject to MEM_WAIT), then CAR_0.
  - Interrupt requests are not resampled inside the chain.
  - CAR_INT4 is not an instruction end.
- Any unencoded CAR value → CAR_0 on the next edge.

Decomposition:
- Shared PARAMS include holds:
  - all CAR_* encodings;
  - register indices PC, SP, SR, CG (R3);
  - opcode field constants: FMT2_PREFIX 6'b000100, JMP_PREFIX 3'b001, F2 op codes.
- Sub-module car_decode: combinational FETCH_WORD → entry CAR, including constant-generator mode mapping.
- The sequencer holds the register, chain-advance, stall and interrupt muxing.

Test Plan:
- RSTn pulsed low while CAR=CAR_IDX_IDX3, no MCLK edge → CAR=CAR_0 at once; after release, FETCH_WORD=0x4405 (MOV R4,R5) → REG_REG, then CAR_0.
- FETCH_WORD=0x54B5 (ADD @R4+,2(R5)) → IND_IDX0..IND_IDX4, then CAR_0 (6 cycles incl. fetch). MEM_WAIT=1 for 2 cycles at IND_IDX1 → CAR held 3 cycles total; INSTR_END=1 only at IND_IDX4.
- Constant generator: 0x4225 (MOV #4,R5) → REG_REG. 0x4315 (src R3, As=01, Ad=0) → REG_REG. 0x4215 (&abs, Ad=0) → IDX_REG0.
- Format 2: 0x1225 (PUSH @R5) → PUSH_IND0..2; 0x1285 (CALL R5) → CALL_REG0..2; 0x1300 (RETI) → RETI0..3; 0x1380 → CAR_0.
- Interrupts:
  - INTREQ=1, GIE=1 during REG_REG → INT0..INT4 (IN_INT=1), then CAR_0.
  - Same with GIE=0 → CAR_0.
  - NMI=1, GIE=0 → INT0.
  - INTREQ asserted at REG_IDX1 only, deasserted by REG_IDX3 → CAR_0.
- FETCH_WORD=0x3C00 (JMP) → JMP0 → CAR_0. Illegal 0x0000 → CAR_0 with no intermediate state.

Source files
------------

// File: rtl/car_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// car_sequencer_pkg
//   Shared constants for the MSP430 microsequencer:
//   - CAR_* control-address encodings (60 states, 6 bits)
//   - register indices PC/SP/SR/CG
//   - instruction-word field constants (format-2 prefix, jump prefix, F2 ops)
//   - helpers: source-mode mapping, last-state and interrupt-state tests
//
//   Each chain is numbered consecutively, so "advance to index+1" is simply
//   CAR+1 in the sequencer. The last state of every chain is listed
//   explicitly in car_is_last().
// -----------------------------------------------------------------------------
package car_sequencer_pkg;

  localparam int CAR_W   = 6;
  localparam int CAR_NUM = 60;

  typedef logic [CAR_W-1:0] car_t;

  // Fetch / decode
  localparam car_t CAR_0         = 6'd0;
  // Format 1: <src mode>_<dst mode>
  localparam car_t CAR_REG_REG   = 6'd1;
  localparam car_t CAR_REG_IDX0  = 6'd2;
  localparam car_t CAR_REG_IDX1  = 6'd3;
  localparam car_t CAR_REG_IDX2  = 6'd4;
  localparam car_t CAR_REG_IDX3  = 6'd5;
  localparam car_t CAR_IND_REG0  = 6'd6;
  localparam car_t CAR_IND_REG1  = 6'd7;
  localparam car_t CAR_IND_IDX0  = 6'd8;
  localparam car_t CAR_IND_IDX1  = 6'd9;
  localparam car_t CAR_IND_IDX2  = 6'd10;
  localparam car_t CAR_IND_IDX3  = 6'd11;
  localparam car_t CAR_IND_IDX4  = 6'd12;
  localparam car_t CAR_IDX_REG0  = 6'd13;
  localparam car_t CAR_IDX_REG1  = 6'd14;
  localparam car_t CAR_IDX_REG2  = 6'd15;
  localparam car_t CAR_IDX_IDX0  = 6'd16;
  localparam car_t CAR_IDX_IDX1  = 6'd17;
  localparam car_t CAR_IDX_IDX2  = 6'd18;
  localparam car_t CAR_IDX_IDX3  = 6'd19;
  localparam car_t CAR_IDX_IDX4  = 6'd20;
  localparam car_t CAR_IDX_IDX5  = 6'd21;
  // Format 2 single-operand ALU ops (RRC/SWPB/RRA/SXT)
  localparam car_t CAR_1OP_REG   = 6'd22;
  localparam car_t CAR_1OP_IND0  = 6'd23;
  localparam car_t CAR_1OP_IND1  = 6'd24;
  localparam car_t CAR_1OP_IND2  = 6'd25;
  localparam car_t CAR_1OP_IDX0  = 6'd26;
  localparam car_t CAR_1OP_IDX1  = 6'd27;
  localparam car_t CAR_1OP_IDX2  = 6'd28;
  localparam car_t CAR_1OP_IDX3  = 6'd29;
  // PUSH
  localparam car_t CAR_PUSH_REG0 = 6'd30;
  localparam car_t CAR_PUSH_REG1 = 6'd31;
  localparam car_t CAR_PUSH_REG2 = 6'd32;
  localparam car_t CAR_PUSH_IND0 = 6'd33;
  localparam car_t CAR_PUSH_IND1 = 6'd34;
  localparam car_t CAR_PUSH_IND2 = 6'd35;
  localparam car_t CAR_PUSH_IDX0 = 6'd36;
  localparam car_t CAR_PUSH_IDX1 = 6'd37;
  localparam car_t CAR_PUSH_IDX2 = 6'd38;
  localparam car_t CAR_PUSH_IDX3 = 6'd39;
  // CALL
  localparam car_t CAR_CALL_REG0 = 6'd40;
  localparam car_t CAR_CALL_REG1 = 6'd41;
  localparam car_t CAR_CALL_REG2 = 6'd42;
  localparam car_t CAR_CALL_IND0 = 6'd43;
  localparam car_t CAR_CALL_IND1 = 6'd44;
  localparam car_t CAR_CALL_IND2 = 6'd45;
  localparam car_t CAR_CALL_IDX0 = 6'd46;
  localparam car_t CAR_CALL_IDX1 = 6'd47;
  localparam car_t CAR_CALL_IDX2 = 6'd48;
  localparam car_t CAR_CALL_IDX3 = 6'd49;
  // RETI
  localparam car_t CAR_RETI0     = 6'd50;
  localparam car_t CAR_RETI1     = 6'd51;
  localparam car_t CAR_RETI2     = 6'd52;
  localparam car_t CAR_RETI3     = 6'd53;
  // Jumps
  localparam car_t CAR_JMP0      = 6'd54;
  // Interrupt entry
  localparam car_t CAR_INT0      = 6'd55;
  localparam car_t CAR_INT1      = 6'd56;
  localparam car_t CAR_INT2      = 6'd57;
  localparam car_t CAR_INT3      = 6'd58;
  localparam car_t CAR_INT4      = 6'd59;

  // Register indices
  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SP = 4'd1;
  localparam logic [3:0] REG_SR = 4'd2;
  localparam logic [3:0] REG_CG = 4'd3;

  // Opcode field constants
  localparam logic [5:0] FMT2_PREFIX = 6'b000100;
  localparam logic [2:0] JMP_PREFIX  = 3'b001;
  localparam logic [2:0] F2_RRC      = 3'b000;
  localparam logic [2:0] F2_SWPB     = 3'b001;
  localparam logic [2:0] F2_RRA      = 3'b010;
  localparam logic [2:0] F2_SXT      = 3'b011;
  localparam logic [2:0] F2_PUSH     = 3'b100;
  localparam logic [2:0] F2_CALL     = 3'b101;
  localparam logic [2:0] F2_RETI     = 3'b110;
  localparam logic [2:0] F2_NOP      = 3'b111;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_IDX = 2'd1,
    SRC_IND = 2'd2
  } src_mode_e;

  // Source addressing mode after constant-generator folding: R3 never
  // touches memory, and R2 only does for As=01 (&abs behaves as indexed).
  function automatic src_mode_e car_src_mode(input logic [3:0] rs,
                                             input logic [1:0] as);
    src_mode_e m;
    unique case (as)
      2'b00:   m = SRC_REG;
      2'b01:   m = (rs == REG_CG) ? SRC_REG : SRC_IDX;
      default: m = (rs == REG_CG || rs == REG_SR) ? SRC_REG : SRC_IND;
    endcase
    return m;
  endfunction

  // Last state of an instruction (successor is CAR_0 or CAR_INT0).
  function automatic logic car_is_last(input car_t c);
    logic r;
    case (c)
      CAR_REG_REG,   CAR_REG_IDX3,  CAR_IND_REG1,  CAR_IND_IDX4,
      CAR_IDX_REG2,  CAR_IDX_IDX5,  CAR_1OP_REG,   CAR_1OP_IND2,
      CAR_1OP_IDX3,  CAR_PUSH_REG2, CAR_PUSH_IND2, CAR_PUSH_IDX3,
      CAR_CALL_REG2, CAR_CALL_IND2, CAR_CALL_IDX3, CAR_RETI3,
      CAR_JMP0:      r = 1'b1;
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic car_is_int(input car_t c);
    return (c >= CAR_INT0) && (c <= CAR_INT4);
  endfunction

endpackage

// File: rtl/car_sequencer_decode.sv
// -----------------------------------------------------------------------------
// car_decode
//   Combinational decode of the fetched instruction word into the entry CAR
//   of its microcode chain. Unrecognised words (including format-2 op 111)
//   decode to CAR_0, i.e. they are skipped without a trap.
//
//   fetch_word_i  in  16  instruction word presented during CAR_0
//   entry_o       out  6  first CAR of the instruction's chain
// -----------------------------------------------------------------------------
module car_decode
  import car_sequencer_pkg::*;
(
  input  logic [15:0] fetch_word_i,
  output car_t        entry_o
);

  logic [3:0] f1_src;
  logic [3:0] f2_reg;
  logic [1:0] as_f;
  logic       ad_f;
  logic [2:0] f2_op;
  src_mode_e  f1_mode;
  src_mode_e  f2_mode;
  logic       unused_bw;

  assign f1_src    = fetch_word_i[11:8];
  assign f2_reg    = fetch_word_i[3:0];
  assign as_f      = fetch_word_i[5:4];
  assign ad_f      = fetch_word_i[7];
  assign f2_op     = fetch_word_i[9:7];
  // Byte/word select only affects the datapath, not sequencing.
  assign unused_bw = fetch_word_i[6];

  assign f1_mode = car_src_mode(f1_src, as_f);
  assign f2_mode = car_src_mode(f2_reg, as_f);

  always_comb begin
    entry_o = CAR_0;
    if (fetch_word_i[15:13] == JMP_PREFIX) begin
      entry_o = CAR_JMP0;
    end else if (fetch_word_i[15:12] >= 4'h4) begin
      unique case (f1_mode)
        SRC_REG: entry_o = ad_f ? CAR_REG_IDX0 : CAR_REG_REG;
        SRC_IND: entry_o = ad_f ? CAR_IND_IDX0 : CAR_IND_REG0;
        SRC_IDX: entry_o = ad_f ? CAR_IDX_IDX0 : CAR_IDX_REG0;
        default: entry_o = CAR_0;
      endcase
    end else if (fetch_word_i[15:10] == FMT2_PREFIX) begin
      unique case (f2_op)
        F2_RRC, F2_SWPB, F2_RRA, F2_SXT: begin
          unique case (f2_mode)
            SRC_REG: entry_o = CAR_1OP_REG;
            SRC_IND: entry_o = CAR_1OP_IND0;
            SRC_IDX: entry_o = CAR_1OP_IDX0;
            default: entry_o = CAR_0;
          endcase
        end
        F2_PUSH: begin
          unique case (f2_mode)
            SRC_REG: entry_o = CAR_PUSH_REG0;
            SRC_IND: entry_o = CAR_PUSH_IND0;
            SRC_IDX: entry_o = CAR_PUSH_IDX0;
            default: entry_o = CAR_0;
          endcase
        end
        F2_CALL: begin
          unique case (f2_mode)
            SRC_REG: entry_o = CAR_CALL_REG0;
            SRC_IND: entry_o = CAR_CALL_IND0;
            SRC_IDX: entry_o = CAR_CALL_IDX0;
            default: entry_o = CAR_0;
          endcase
        end
        F2_RETI: entry_o = CAR_RETI0;   // addressing mode irrelevant
        F2_NOP:  entry_o = CAR_0;
        default: entry_o = CAR_0;
      endcase
    end
  end

endmodule

// File: rtl/car_sequencer.sv
// -----------------------------------------------------------------------------
// car_sequencer
//   MSP430 microsequencer: owns the Control Address Register (CAR).
//   CAR_0 decodes FETCH_WORD into a chain entry; chain states step by one;
//   the last state of an instruction branches to CAR_INT0 when an interrupt
//   is pending, else back to CAR_0. MEM_WAIT freezes CAR in every state.
//
//   MCLK        in   1         clock, rising edge
//   RSTn        in   1         async active-low reset (CAR -> CAR_0)
//   FETCH_WORD  in   16        instruction word during CAR_0
//   MEM_WAIT    in   1         memory not ready, hold CAR
//   INTREQ      in   1         maskable interrupt pending
//   GIE         in   1         current SR.GIE
//   NMI         in   1         non-maskable interrupt pending
//   CAR         out  CAR_BITS  control address
//   IN_INT      out  1         CAR is in CAR_INT0..CAR_INT4
//   INSTR_END   out  1         CAR is the last state of an instruction
// -----------------------------------------------------------------------------
module car_sequencer
  import car_sequencer_pkg::*;
#(
  parameter int CAR_BITS = 6
) (
  input  logic                MCLK,
  input  logic                RSTn,
  input  logic [15:0]         FETCH_WORD,
  input  logic                MEM_WAIT,
  input  logic                INTREQ,
  input  logic                GIE,
  input  logic                NMI,
  output logic [CAR_BITS-1:0] CAR,
  output logic                IN_INT,
  output logic                INSTR_END
);

  logic [CAR_BITS-1:0] car_q;
  logic [CAR_BITS-1:0] car_d;
  car_t                cur;
  car_t                dec_entry;
  logic                enc_ok;
  logic                irq_take;

  car_decode u_decode (
    .fetch_word_i (FETCH_WORD),
    .entry_o      (dec_entry)
  );

  // Low CAR_W bits select the state; any set bit above them, or a value past
  // the last encoding, is treated as unencoded and recovers to CAR_0.
  assign cur    = car_t'(car_q);
  assign enc_ok = (car_q == CAR_BITS'(cur)) && (cur < car_t'(CAR_NUM));

  // GIE is taken live so RETI3 sees the SR it has just restored.
  assign irq_take = NMI | (INTREQ & GIE);

  always_comb begin
    car_d = car_q;
    if (!MEM_WAIT) begin
      if (!enc_ok)
        car_d = CAR_BITS'(CAR_0);
      else if (cur == CAR_0)
        car_d = CAR_BITS'(dec_entry);
      else if (cur == CAR_INT4)
        car_d = CAR_BITS'(CAR_0);
      else if (car_is_last(cur))
        car_d = irq_take ? CAR_BITS'(CAR_INT0) : CAR_BITS'(CAR_0);
      else
        car_d = CAR_BITS'(car_t'(cur + car_t'(1)));
    end
  end

  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) car_q <= CAR_BITS'(CAR_0);
    else       car_q <= car_d;
  end

  assign CAR       = car_q;
  assign IN_INT    = enc_ok && car_is_int(cur);
  assign INSTR_END = enc_ok && car_is_last(cur);

endmodule

// File: tb/tb_car_sequencer.sv
module tb_car_sequencer;
  import car_sequencer_pkg::*;

  logic        MCLK = 1'b0;
  logic        RSTn;
  logic [15:0] FETCH_WORD;
  logic        MEM_WAIT, INTREQ, GIE, NMI;
  logic [5:0]  CAR;
  logic        IN_INT, INSTR_END;

  int checks   = 0;
  int failures = 0;

  car_sequencer #(.CAR_BITS(6)) dut (
    .MCLK       (MCLK),
    .RSTn       (RSTn),
    .FETCH_WORD (FETCH_WORD),
    .MEM_WAIT   (MEM_WAIT),
    .INTREQ     (INTREQ),
    .GIE        (GIE),
    .NMI        (NMI),
    .CAR        (CAR),
    .IN_INT     (IN_INT),
    .INSTR_END  (INSTR_END)
  );

  always #5 MCLK = ~MCLK;

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; FETCH_WORD = 16'h4405; MEM_WAIT = 1'b0;
    INTREQ = 1'b0; GIE = 1'b0; NMI = 1'b0;
    #2;
    checks++;
    if (CAR !== CAR_0 || IN_INT !== 1'b0 || INSTR_END !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: CAR=%0d IN_INT=%b INSTR_END=%b, want 0 0 0", CAR, IN_INT, INSTR_END);
    end
    tick(); tick();
    checks++;
    if (CAR !== CAR_0) begin
      failures++; $display("FAIL reset_hold: CAR=%0d want %0d", CAR, CAR_0);
    end
    RSTn = 1'b1; FETCH_WORD = 16'h0000;
    tick();
    checks++;
    if (CAR !== CAR_0) begin
      failures++; $display("FAIL reset_illegal_fetch: CAR=%0d want %0d", CAR, CAR_0);
    end
  endtask

  task automatic test_reset_midchain();
    car_t ii[4] = '{CAR_IDX_IDX0, CAR_IDX_IDX1, CAR_IDX_IDX2, CAR_IDX_IDX3};
    FETCH_WORD = 16'h5495;  // ADD 2(R4),x(R5): IDX src, indexed dst
    for (int i = 0; i < 4; i++) begin
      tick();
      FETCH_WORD = 16'h0000;
      checks++;
      if (CAR !== ii[i]) begin
        failures++; $display("FAIL midchain_walk[%0d]: CAR=%0d want %0d", i, CAR, ii[i]);
      end
    end
    RSTn = 1'b0;
    #2;
    checks++;
    if (CAR !== CAR_0 || IN_INT !== 1'b0 || INSTR_END !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: CAR=%0d IN_INT=%b INSTR_END=%b, want 0 0 0", CAR, IN_INT, INSTR_END);
    end
    #1;
    RSTn = 1'b1; FETCH_WORD = 16'h4405;
    tick();
    FETCH_WORD = 16'h0000;
    checks++;
    if (CAR !== CAR_REG_REG || INSTR_END !== 1'b1) begin
      failures++;
      $display("FAIL first_fetch: CAR=%0d INSTR_END=%b want %0d 1", CAR, INSTR_END, CAR_REG_REG);
    end
    tick();
    checks++;
    if (CAR !== CAR_0) begin
      failures++; $display("FAIL first_fetch_end: CAR=%0d want %0d", CAR, CAR_0);
    end
  endtask

  task automatic test_chains();
    logic [15:0] words[17] = '{16'h4405, 16'h4225, 16'h4315, 16'h4324, 16'h4215,
                               16'h4425, 16'h1225, 16'h1285, 16'h12B2, 16'h1215,
                               16'h1095, 16'h1300, 16'h1380, 16'h3C00, 16'h0000,
                               16'h0FFF, 16'h4234};
    car_t exp[$] = '{
      CAR_REG_REG, CAR_0,
      CAR_REG_REG, CAR_0,
      CAR_REG_REG, CAR_0,
      CAR_REG_REG, CAR_0,
      CAR_IDX_REG0, CAR_IDX_REG1, CAR_IDX_REG2, CAR_0,
      CAR_IND_REG0, CAR_IND_REG1, CAR_0,
      CAR_PUSH_IND0, CAR_PUSH_IND1, CAR_PUSH_IND2, CAR_0,
      CAR_CALL_REG0, CAR_CALL_REG1, CAR_CALL_REG2, CAR_0,
      CAR_CALL_REG0, CAR_CALL_REG1, CAR_CALL_REG2, CAR_0,
      CAR_PUSH_IDX0, CAR_PUSH_IDX1, CAR_PUSH_IDX2, CAR_PUSH_IDX3, CAR_0,
      CAR_1OP_IDX0, CAR_1OP_IDX1, CAR_1OP_IDX2, CAR_1OP_IDX3, CAR_0,
      CAR_RETI0, CAR_RETI1, CAR_RETI2, CAR_RETI3, CAR_0,
      CAR_0,
      CAR_JMP0, CAR_0,
      CAR_0,
      CAR_0,
      CAR_REG_REG, CAR_0};
    int   k = 0;
    logic exp_end;
    foreach (words[w]) begin
      FETCH_WORD = words[w];
      tick();
      FETCH_WORD = 16'h0000;
      for (int n = 0; n < 8; n++) begin
        exp_end = (exp[k] != CAR_0) && (exp[k+1] == CAR_0);
        checks++;
        if (CAR !== exp[k] || INSTR_END !== exp_end || IN_INT !== 1'b0) begin
          failures++;
          $display("FAIL chain word=%h step=%0d: CAR=%0d INSTR_END=%b IN_INT=%b want %0d %b 0",
                   words[w], n, CAR, INSTR_END, IN_INT, exp[k], exp_end);
        end
        if (exp[k] == CAR_0) begin
          k++;
          break;
        end
        k++;
        tick();
      end
    end
  endtask

  task automatic test_stall();
    car_t seq[6] = '{CAR_IND_IDX1, CAR_IND_IDX1, CAR_IND_IDX2, CAR_IND_IDX3, CAR_IND_IDX4, CAR_0};
    // Stall at CAR_0: no decode.
    MEM_WAIT = 1'b1; FETCH_WORD = 16'h4405;
    tick();
    checks++;
    if (CAR !== CAR_0) begin
      failures++; $display("FAIL stall_car0: CAR=%0d want %0d", CAR, CAR_0);
    end
    MEM_WAIT = 1'b0; FETCH_WORD = 16'h54B5;
    tick();
    FETCH_WORD = 16'h0000;
    checks++;
    if (CAR !== CAR_IND_IDX0 || INSTR_END !== 1'b0) begin
      failures++; $display("FAIL ind_idx_entry: CAR=%0d INSTR_END=%b want %0d 0", CAR, INSTR_END, CAR_IND_IDX0);
    end
    tick();
    checks++;
    if (CAR !== CAR_IND_IDX1) begin
      failures++; $display("FAIL ind_idx1: CAR=%0d want %0d", CAR, CAR_IND_IDX1);
    end
    MEM_WAIT = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) MEM_WAIT = 1'b0;
      checks++;
      if (CAR !== seq[i] || INSTR_END !== (seq[i] == CAR_IND_IDX4)) begin
        failures++;
        $display("FAIL stall_walk[%0d]: CAR=%0d INSTR_END=%b want %0d %b", i, CAR, INSTR_END, seq[i], seq[i] == CAR_IND_IDX4);
      end
    end
  endtask

  task automatic test_interrupts();
    car_t ints[5] = '{CAR_INT0, CAR_INT1, CAR_INT2, CAR_INT3, CAR_INT4};
    // Maskable, enabled; request stays high through the whole chain.
    INTREQ = 1'b1; GIE = 1'b1; FETCH_WORD = 16'h4405;
    tick();
    FETCH_WORD = 16'h0000;
    checks++;
    if (CAR !== CAR_REG_REG || INSTR_END !== 1'b1) begin
      failures++; $display("FAIL irq_last: CAR=%0d INSTR_END=%b want %0d 1", CAR, INSTR_END, CAR_REG_REG);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (CAR !== ints[i] || IN_INT !== 1'b1 || INSTR_END !== 1'b0) begin
        failures++;
        $display("FAIL irq_chain[%0d]: CAR=%0d IN_INT=%b INSTR_END=%b want %0d 1 0", i, CAR, IN_INT, INSTR_END, ints[i]);
      end
    end
    tick();
    checks++;
    if (CAR !== CAR_0 || IN_INT !== 1'b0) begin
      failures++; $display("FAIL irq_exit: CAR=%0d IN_INT=%b want %0d 0", CAR, IN_INT, CAR_0);
    end
    // Masked.
    GIE = 1'b0; FETCH_WORD = 16'h4405;
    tick(); FETCH_WORD = 16'h0000; tick();
    checks++;
    if (CAR !== CAR_0) begin
      failures++; $display("FAIL irq_masked: CAR=%0d want %0d", CAR, CAR_0);
    end
    // NMI ignores GIE.
    INTREQ = 1'b0; NMI = 1'b1; FETCH_WORD = 16'h4405;
    tick(); FETCH_WORD = 16'h0000; tick();
    checks++;
    if (CAR !== CAR_INT0 || IN_INT !== 1'b1) begin
      failures++; $display("FAIL nmi_taken: CAR=%0d IN_INT=%b want %0d 1", CAR, IN_INT, CAR_INT0);
    end
    NMI = 1'b0;
    repeat (5) tick();
    checks++;
    if (CAR !== CAR_0) begin
      failures++; $display("FAIL nmi_exit: CAR=%0d want %0d", CAR, CAR_0);
    end
    // Request only mid-instruction: not seen at the boundary.
    FETCH_WORD = 16'h4485;
    tick(); FETCH_WORD = 16'h0000; tick();
    checks++;
    if (CAR !== CAR_REG_IDX1) begin
      failures++; $display("FAIL transient_idx1: CAR=%0d want %0d", CAR, CAR_REG_IDX1);
    end
    INTREQ = 1'b1; GIE = 1'b1;
    tick();
    INTREQ = 1'b0;
    tick();
    checks++;
    if (CAR !== CAR_REG_IDX3 || INSTR_END !== 1'b1) begin
      failures++; $display("FAIL transient_idx3: CAR=%0d INSTR_END=%b want %0d 1", CAR, INSTR_END, CAR_REG_IDX3);
    end
    tick();
    checks++;
    if (CAR !== CAR_0) begin
      failures++; $display("FAIL transient_end: CAR=%0d want %0d", CAR, CAR_0);
    end
    // RETI3 uses GIE as restored that cycle.
    INTREQ = 1'b1; GIE = 1'b0; FETCH_WORD = 16'h1300;
    tick(); FETCH_WORD = 16'h0000; tick(); tick(); tick();
    checks++;
    if (CAR !== CAR_RETI3 || INSTR_END !== 1'b1) begin
      failures++; $display("FAIL reti3: CAR=%0d INSTR_END=%b want %0d 1", CAR, INSTR_END, CAR_RETI3);
    end
    GIE = 1'b1;
    tick();
    checks++;
    if (CAR !== CAR_INT0) begin
      failures++; $display("FAIL reti_gie: CAR=%0d want %0d", CAR, CAR_INT0);
    end
    INTREQ = 1'b0; GIE = 1'b0;
    repeat (5) tick();
    // Stall at the boundary defers sampling.
    INTREQ = 1'b1; GIE = 1'b1; FETCH_WORD = 16'h4405;
    tick();
    FETCH_WORD = 16'h0000; MEM_WAIT = 1'b1;
    tick();
    checks++;
    if (CAR !== CAR_REG_REG) begin
      failures++; $display("FAIL stall_last: CAR=%0d want %0d", CAR, CAR_REG_REG);
    end
    INTREQ = 1'b0; MEM_WAIT = 1'b0;
    tick();
    checks++;
    if (CAR !== CAR_0) begin
      failures++; $display("FAIL stall_defer: CAR=%0d want %0d", CAR, CAR_0);
    end
    GIE = 1'b0;
  endtask

  task automatic test_back_to_back();
    car_t seq[4] = '{CAR_REG_REG, CAR_0, CAR_REG_REG, CAR_0};
    FETCH_WORD = 16'h4405;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (CAR !== seq[i]) begin
        failures++; $display("FAIL back_to_back[%0d]: CAR=%0d want %0d", i, CAR, seq[i]);
      end
    end
    FETCH_WORD = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_reset_midchain();
    test_chains();
    test_stall();
    test_interrupts();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
